// File: rtl/dm_arbiter.sv
// dm_arbiter: two-requester arbiter for the single data-memory port.
//   Port 0 = load/store pipeline, port 1 = page-table walker / debug access.
//   Grants are locked while a request stalls, accepted requests are tracked
//   in an in-order owner-ID FIFO, and each response is steered back to the
//   port that issued it.
// Optional macro DM_ARB_ROUND_ROBIN_EN: when defined, priority alternates
//   between ports after each accept. When undefined (default), port 0 has
//   fixed priority with a starvation guard that forces a port-1 win after
//   STARVE_LIMIT consecutive contended port-0 accepts.
module dm_arbiter #(
   parameter int unsigned MAX_OUTST    = 2,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic        clk,
   input  logic        rst_n,

   input  logic [63:0] p0_req_addr,
   input  logic [63:0] p0_req_wdata,
   input  logic [7:0]  p0_req_wmask,
   input  logic        p0_req_wen,
   input  logic        p0_req_valid,
   output logic        p0_req_ready,
   output logic [63:0] p0_resp_rdata,
   output logic        p0_resp_valid,

   input  logic [63:0] p1_req_addr,
   input  logic [63:0] p1_req_wdata,
   input  logic [7:0]  p1_req_wmask,
   input  logic        p1_req_wen,
   input  logic        p1_req_valid,
   output logic        p1_req_ready,
   output logic [63:0] p1_resp_rdata,
   output logic        p1_resp_valid,

   output logic [63:0] dm_req_addr,
   output logic [63:0] dm_req_wdata,
   output logic [7:0]  dm_req_wmask,
   output logic        dm_req_wen,
   output logic        dm_req_valid,
   input  logic        dm_req_ready,
   input  logic [63:0] dm_resp_rdata,
   input  logic        dm_resp_valid,

   output logic        arb_busy,
   output logic        arb_resp_err
);

   localparam int unsigned PtrW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
   localparam int unsigned CntW = $clog2(MAX_OUTST) + 1;

   // Lock keeps the grant on a stalled request's port
   logic            lock_q;
   logic            lock_port_q;

   // Owner-ID FIFO: one bit per entry, 0 = port 0, 1 = port 1
   logic [MAX_OUTST-1:0] owner_q;
   logic [PtrW-1:0]      wr_ptr_q;
   logic [PtrW-1:0]      rd_ptr_q;
   logic [CntW-1:0]      cnt_q;
   logic [CntW-1:0]      cnt_d;

   logic            err_q;

   logic            grant;
   logic            prio_win;
   logic            gnt_valid;
   logic            fifo_full;
   logic            fifo_empty;
   logic            req_ok;
   logic            push;
   logic            pop;
   logic            head_id;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      if (p == PtrW'(MAX_OUTST - 1)) begin
         return '0;
      end
      return p + PtrW'(1);
   endfunction

   assign fifo_full  = (cnt_q == CntW'(MAX_OUTST));
   assign fifo_empty = (cnt_q == '0);
   assign head_id    = owner_q[rd_ptr_q];

   // Grant selection: lock first, then priority on contention, else the lone requester
   always_comb begin
      grant = 1'b0;
      if (lock_q) begin
         grant = lock_port_q;
      end else if (p0_req_valid && p1_req_valid) begin
         grant = prio_win;
      end else begin
         grant = p1_req_valid;
      end
   end

   assign gnt_valid = grant ? p1_req_valid : p0_req_valid;

   // Internal handshake terms; a full FIFO blocks grants even if a pop is in flight
   assign req_ok = gnt_valid && !fifo_full;
   assign push   = req_ok && dm_req_ready;
   assign pop    = dm_resp_valid && !fifo_empty;

   // Zero-cycle payload mux from the granted port
   always_comb begin
      dm_req_addr  = p0_req_addr;
      dm_req_wdata = p0_req_wdata;
      dm_req_wmask = p0_req_wmask;
      dm_req_wen   = p0_req_wen;
      if (grant) begin
         dm_req_addr  = p1_req_addr;
         dm_req_wdata = p1_req_wdata;
         dm_req_wmask = p1_req_wmask;
         dm_req_wen   = p1_req_wen;
      end
   end

   // Handshake outputs are forced low while reset is asserted
   assign dm_req_valid  = rst_n && req_ok;
   assign p0_req_ready  = rst_n && push && !grant;
   assign p1_req_ready  = rst_n && push && grant;

   assign p0_resp_valid = rst_n && pop && !head_id;
   assign p1_resp_valid = rst_n && pop && head_id;
   assign p0_resp_rdata = dm_resp_rdata;
   assign p1_resp_rdata = dm_resp_rdata;

   assign arb_busy     = !fifo_empty || lock_q;
   assign arb_resp_err = err_q;

   // Grant lock: set on a stalled request, released on the accepting cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_q      <= 1'b0;
         lock_port_q <= 1'b0;
      end else if (req_ok && !dm_req_ready) begin
         lock_q      <= 1'b1;
         lock_port_q <= grant;
      end else if (push) begin
         lock_q      <= 1'b0;
      end
   end

   // Occupancy next state; simultaneous push and pop leaves it unchanged
   always_comb begin
      cnt_d = cnt_q;
      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + CntW'(1);
         2'b01:   cnt_d = cnt_q - CntW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Owner FIFO storage and pointers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push) begin
            owner_q[wr_ptr_q] <= grant;
            wr_ptr_q          <= ptr_inc(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         cnt_q <= cnt_d;
      end
   end

   // Sticky error: a response arrived with nothing outstanding
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (dm_resp_valid && fifo_empty) begin
         err_q <= 1'b1;
      end
   end

`ifdef DM_ARB_ROUND_ROBIN_EN
   logic prio_q;

   assign prio_win = prio_q;

   // Round-robin pointer hands priority to the other port after every accept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio_q <= 1'b0;
      end else if (push) begin
         prio_q <= !grant;
      end
   end
`else
   localparam int unsigned StW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

   logic [StW-1:0] starve_q;

   // Port 0 wins contention unless port 1 has been starved STARVE_LIMIT times
   assign prio_win = (starve_q == StW'(STARVE_LIMIT));

   // Starve counter: count contended port-0 accepts, clear on any port-1 accept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_q <= '0;
      end else if (push && grant) begin
         starve_q <= '0;
      end else if (push && !grant && p1_req_valid && !prio_win) begin
         starve_q <= starve_q + StW'(1);
      end
   end
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: table-driven grant/ready vectors plus
// hand-written sequences for stalls, full FIFO, starvation and reset.
`timescale 1ns/1ps
module tb_dm_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] p0_req_addr, p0_req_wdata, p1_req_addr, p1_req_wdata;
   logic [7:0]  p0_req_wmask, p1_req_wmask;
   logic        p0_req_wen, p0_req_valid, p0_req_ready, p0_resp_valid;
   logic        p1_req_wen, p1_req_valid, p1_req_ready, p1_resp_valid;
   logic [63:0] p0_resp_rdata, p1_resp_rdata;
   logic [63:0] dm_req_addr, dm_req_wdata, dm_resp_rdata;
   logic [7:0]  dm_req_wmask;
   logic        dm_req_wen, dm_req_valid, dm_req_ready, dm_resp_valid;
   logic        arb_busy, arb_resp_err;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   logic        own_q[$];
   logic [63:0] cur_rd;

   typedef struct {
      logic        p0v;
      logic        p1v;
      logic        rdy;
      logic        dv;
      logic        r0;
      logic        r1;
      logic        wen;
      logic [7:0]  wmask;
      logic [63:0] addr;
      logic [63:0] wdata;
   } vec_t;

   vec_t vt[6];

   dm_arbiter #(.MAX_OUTST(2), .STARVE_LIMIT(8)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .p0_req_addr   (p0_req_addr),
      .p0_req_wdata  (p0_req_wdata),
      .p0_req_wmask  (p0_req_wmask),
      .p0_req_wen    (p0_req_wen),
      .p0_req_valid  (p0_req_valid),
      .p0_req_ready  (p0_req_ready),
      .p0_resp_rdata (p0_resp_rdata),
      .p0_resp_valid (p0_resp_valid),
      .p1_req_addr   (p1_req_addr),
      .p1_req_wdata  (p1_req_wdata),
      .p1_req_wmask  (p1_req_wmask),
      .p1_req_wen    (p1_req_wen),
      .p1_req_valid  (p1_req_valid),
      .p1_req_ready  (p1_req_ready),
      .p1_resp_rdata (p1_resp_rdata),
      .p1_resp_valid (p1_resp_valid),
      .dm_req_addr   (dm_req_addr),
      .dm_req_wdata  (dm_req_wdata),
      .dm_req_wmask  (dm_req_wmask),
      .dm_req_wen    (dm_req_wen),
      .dm_req_valid  (dm_req_valid),
      .dm_req_ready  (dm_req_ready),
      .dm_resp_rdata (dm_resp_rdata),
      .dm_resp_valid (dm_resp_valid),
      .arb_busy      (arb_busy),
      .arb_resp_err  (arb_resp_err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, required $finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc_end();
      @(posedge clk);
      #1;
      dm_resp_valid = 1'b0;
   endtask

   task automatic resp_start(input logic [63:0] data);
      dm_resp_valid = 1'b1;
      dm_resp_rdata = data;
      cur_rd        = data;
   endtask

   // Called at the negedge of a response cycle: pops the expected owner
   task automatic resp_check();
      logic o;
      if (own_q.size() == 0) begin
         check("resp_orphan_p0_valid", p0_resp_valid, 1'b0);
         check("resp_orphan_p1_valid", p1_resp_valid, 1'b0);
      end else begin
         o = own_q.pop_front();
         check("resp_p0_valid", p0_resp_valid, !o);
         check("resp_p1_valid", p1_resp_valid, o);
         check("resp_p0_rdata", p0_resp_rdata, cur_rd);
         check("resp_p1_rdata", p1_resp_rdata, cur_rd);
      end
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      p0_req_addr   = 64'h1000;
      p0_req_wdata  = 64'h1111_1111_1111_1111;
      p0_req_wmask  = 8'hFF;
      p0_req_wen    = 1'b0;
      p0_req_valid  = 1'b0;
      p1_req_addr   = 64'h2000;
      p1_req_wdata  = 64'h2222_2222_2222_2222;
      p1_req_wmask  = 8'h0F;
      p1_req_wen    = 1'b1;
      p1_req_valid  = 1'b0;
      dm_req_ready  = 1'b0;
      dm_resp_valid = 1'b0;
      dm_resp_rdata = '0;
      own_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      vt[0] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 64'h1000, 64'h1111_1111_1111_1111};
      vt[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h0F, 64'h2000, 64'h2222_2222_2222_2222};
      vt[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 64'h1000, 64'h1111_1111_1111_1111};
      vt[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 64'h1000, 64'h1111_1111_1111_1111};
      vt[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 64'h1000, 64'h1111_1111_1111_1111};
      vt[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h0F, 64'h2000, 64'h2222_2222_2222_2222};

      // Reset state, with a request driven while reset is held
      rst_n        = 1'b0;
      p0_req_valid = 1'b1;
      p1_req_valid = 1'b0;
      dm_req_ready = 1'b1;
      dm_resp_valid = 1'b1;
      dm_resp_rdata = 64'h0;
      #3;
      check("rst_dm_req_valid", dm_req_valid, 1'b0);
      check("rst_p0_req_ready", p0_req_ready, 1'b0);
      check("rst_p0_resp_valid", p0_resp_valid, 1'b0);
      check("rst_arb_busy", arb_busy, 1'b0);
      check("rst_arb_resp_err", arb_resp_err, 1'b0);
      do_reset();

      // Table-driven grant / ready vectors, each from a fresh reset
      for (int i = 0; i < 6; i++) begin
         do_reset();
         p0_req_valid = vt[i].p0v;
         p1_req_valid = vt[i].p1v;
         dm_req_ready = vt[i].rdy;
         @(negedge clk);
         check("vec_dm_req_valid", dm_req_valid, vt[i].dv);
         check("vec_p0_req_ready", p0_req_ready, vt[i].r0);
         check("vec_p1_req_ready", p1_req_ready, vt[i].r1);
         if (vt[i].dv) begin
            check("vec_dm_req_addr", dm_req_addr, vt[i].addr);
            check("vec_dm_req_wdata", dm_req_wdata, vt[i].wdata);
            check("vec_dm_req_wmask", dm_req_wmask, vt[i].wmask);
            check("vec_dm_req_wen", dm_req_wen, vt[i].wen);
         end
         if (vt[i].r0) own_q.push_back(1'b0);
         if (vt[i].r1) own_q.push_back(1'b1);
         cyc_end();
         p0_req_valid = 1'b0;
         p1_req_valid = 1'b0;
         dm_req_ready = 1'b0;
         if (vt[i].r0 || vt[i].r1) begin
            resp_start(64'hA000 + 64'(i));
            @(negedge clk);
            resp_check();
            cyc_end();
         end
      end

      // Single port-0 load, response two cycles after accept
      do_reset();
      p0_req_valid = 1'b1;
      dm_req_ready = 1'b1;
      @(negedge clk);
      check("ld_p0_req_ready", p0_req_ready, 1'b1);
      check("ld_dm_req_addr", dm_req_addr, 64'h1000);
      own_q.push_back(1'b0);
      cyc_end();
      p0_req_valid = 1'b0;
      @(negedge clk);
      check("ld_p0_req_ready_once", p0_req_ready, 1'b0);
      check("ld_arb_busy", arb_busy, 1'b1);
      cyc_end();
      resp_start(64'hDEADBEEF);
      @(negedge clk);
      resp_check();
      cyc_end();
      @(negedge clk);
      check("ld_arb_busy_idle", arb_busy, 1'b0);

      // Both valid, D-mem stalls 3 cycles: grant stays on port 0, then port 1
      do_reset();
      p0_req_valid = 1'b1;
      p1_req_valid = 1'b1;
      for (int c = 0; c < 4; c++) begin
         dm_req_ready = (c == 3);
         @(negedge clk);
         check("stall_dm_req_addr", dm_req_addr, 64'h1000);
         check("stall_p0_req_ready", p0_req_ready, (c == 3));
         check("stall_p1_req_ready", p1_req_ready, 1'b0);
         if (c == 3) own_q.push_back(1'b0);
         cyc_end();
      end
      p0_req_valid = 1'b0;
      @(negedge clk);
      check("stall_p1_next_ready", p1_req_ready, 1'b1);
      check("stall_p1_next_addr", dm_req_addr, 64'h2000);
      own_q.push_back(1'b1);
      cyc_end();
      p1_req_valid = 1'b0;
      dm_req_ready = 1'b0;
      for (int r = 0; r < 2; r++) begin
         resp_start(64'hC000 + 64'(r));
         @(negedge clk);
         resp_check();
         cyc_end();
      end

      // Full FIFO: third request blocked until (and not during) the first pop
      do_reset();
      dm_req_ready = 1'b1;
      p0_req_valid = 1'b1;
      @(negedge clk);
      check("full_acc0_p0_ready", p0_req_ready, 1'b1);
      own_q.push_back(1'b0);
      cyc_end();
      p0_req_valid = 1'b0;
      p1_req_valid = 1'b1;
      @(negedge clk);
      check("full_acc1_p1_ready", p1_req_ready, 1'b1);
      own_q.push_back(1'b1);
      cyc_end();
      p1_req_valid = 1'b0;
      p0_req_addr  = 64'h3000;
      p0_req_valid = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         check("full_blocked_dv", dm_req_valid, 1'b0);
         check("full_blocked_p0_ready", p0_req_ready, 1'b0);
         check("full_arb_busy", arb_busy, 1'b1);
         cyc_end();
      end
      resp_start(64'h1111_0001);
      @(negedge clk);
      resp_check();
      check("full_no_bypass_dv", dm_req_valid, 1'b0);
      cyc_end();
      @(negedge clk);
      check("full_acc2_dv", dm_req_valid, 1'b1);
      check("full_acc2_p0_ready", p0_req_ready, 1'b1);
      check("full_acc2_addr", dm_req_addr, 64'h3000);
      own_q.push_back(1'b0);
      cyc_end();
      p0_req_valid = 1'b0;
      p0_req_addr  = 64'h1000;
      for (int r = 0; r < 2; r++) begin
         resp_start(64'h1111_0002 + 64'(r));
         @(negedge clk);
         resp_check();
         cyc_end();
      end
      @(negedge clk);
      check("full_drained_busy", arb_busy, 1'b0);

      // Continuous contention: starvation guard or round-robin alternation
      do_reset();
      p0_req_valid = 1'b1;
      p1_req_valid = 1'b1;
      dm_req_ready = 1'b1;
      for (int k = 0; k < 18; k++) begin
         logic exp_p1;
`ifdef DM_ARB_ROUND_ROBIN_EN
         exp_p1 = ((k % 2) == 1);
`else
         exp_p1 = ((k % 9) == 8);
`endif
         if (k > 0) resp_start(64'hB000 + 64'(k));
         @(negedge clk);
         if (k > 0) resp_check();
         check("contend_p0_ready", p0_req_ready, !exp_p1);
         check("contend_p1_ready", p1_req_ready, exp_p1);
         own_q.push_back(exp_p1);
         cyc_end();
      end
      p0_req_valid = 1'b0;
      p1_req_valid = 1'b0;
      resp_start(64'hB0FF);
      @(negedge clk);
      resp_check();
      cyc_end();
      @(negedge clk);
      check("contend_drained_busy", arb_busy, 1'b0);

      // Orphan response sets the sticky error; async reset clears everything
      do_reset();
      resp_start(64'h55);
      @(negedge clk);
      resp_check();
      check("err_not_yet", arb_resp_err, 1'b0);
      cyc_end();
      @(negedge clk);
      check("err_set", arb_resp_err, 1'b1);
      p0_req_valid = 1'b1;
      dm_req_ready = 1'b1;
      @(negedge clk);
      check("err_acc_p0_ready", p0_req_ready, 1'b1);
      own_q.push_back(1'b0);
      cyc_end();
      dm_req_ready = 1'b0;
      @(negedge clk);
      check("err_outst_busy", arb_busy, 1'b1);
      check("err_still_set", arb_resp_err, 1'b1);
      @(posedge clk);
      #3;
      dm_req_ready = 1'b1;
      rst_n        = 1'b0;
      own_q.delete();
      #1;
      check("midrst_err", arb_resp_err, 1'b0);
      check("midrst_busy", arb_busy, 1'b0);
      check("midrst_dv", dm_req_valid, 1'b0);
      check("midrst_p0_ready", p0_req_ready, 1'b0);
      @(posedge clk);
      #1;
      p0_req_valid = 1'b0;
      dm_req_ready = 1'b0;
      rst_n        = 1'b1;
      resp_start(64'h66);
      @(negedge clk);
      resp_check();
      cyc_end();
      @(negedge clk);
      check("postrst_err", arb_resp_err, 1'b1);
      check("postrst_busy", arb_busy, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
